// File: rtl/wide_add_sequencer.sv
// Multi-precision adder controller: walks one shared ADD_W-bit adder over DATA_W/ADD_W words, LSW first.
// Optional subtract mode (adds in_sub) is enabled by defining WIDE_ADD_SUB_EN.
module wide_add_sequencer #(
    parameter int DATA_W = 256,
    parameter int ADD_W  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_cin,
`ifdef WIDE_ADD_SUB_EN
    input  logic              in_sub,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic              out_cout,
    output logic              busy,
    output logic [ADD_W-1:0]  add_a,
    output logic [ADD_W-1:0]  add_b,
    output logic              add_cin,
    input  logic [ADD_W-1:0]  add_sum,
    input  logic              add_cout
);

    localparam int NWORDS = DATA_W / ADD_W;
    localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NWORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              carry_q;
    logic              sub_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] sum_q;
    logic              cout_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              busy_q;
    logic              sub_d;
    logic              carry_d;

`ifdef WIDE_ADD_SUB_EN
    assign sub_d = in_sub;
`else
    assign sub_d = 1'b0;
`endif

    // Subtraction is A + ~B + 1, so the initial carry is forced high and in_cin is dropped.
    assign carry_d = sub_d ? 1'b1 : in_cin;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // in_ready is high only in IDLE; out_valid is high only in DONE and holds until out_ready.
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state_q == RUN) begin
            add_a   = a_q[int'(cnt_q) * ADD_W +: ADD_W];
            add_b   = b_q[int'(cnt_q) * ADD_W +: ADD_W] ^ {ADD_W{sub_q}};
            add_cin = carry_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            sub_q       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= in_a;
                        b_q        <= in_b;
                        sub_q      <= sub_d;
                        carry_q    <= carry_d;
                        cnt_q      <= '0;
                        state_q    <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    sum_q[int'(cnt_q) * ADD_W +: ADD_W] <= add_sum;
                    carry_q <= add_cout;
                    if (cnt_q == LAST_WORD) begin
                        cout_q      <= add_cout;
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    // Result registers are left untouched after the handshake.
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer with a behavioural model of the shared adder.
// Subtract scenarios run only when WIDE_ADD_SUB_EN is defined.
module tb_wide_add_sequencer;

  localparam int DATA_W = 256;
  localparam int ADD_W  = 64;
  localparam int NWORDS = DATA_W / ADD_W;
  localparam int TMO    = 60;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              in_cin;
`ifdef WIDE_ADD_SUB_EN
  logic              in_sub;
`endif
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_sum;
  logic              out_cout;
  logic              busy;
  logic [ADD_W-1:0]  add_a;
  logic [ADD_W-1:0]  add_b;
  logic              add_cin;
  logic [ADD_W-1:0]  add_sum;
  logic              add_cout;

  logic [DATA_W:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // External shared adder, settles within the cycle.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{ADD_W{1'b0}}, add_cin};

  wide_add_sequencer #(.DATA_W(DATA_W), .ADD_W(ADD_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
`ifdef WIDE_ADD_SUB_EN
    .in_sub   (in_sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout),
    .busy     (busy),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1);
  end

  // ---------------- model ----------------
  function automatic logic [DATA_W:0] model(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                            input logic cin, input logic sub);
    logic [DATA_W-1:0] bb;
    logic              c;
    bb = sub ? ~b : b;
    c  = sub ? 1'b1 : cin;
    return {1'b0, a} + {1'b0, bb} + {{DATA_W{1'b0}}, c};
  endfunction

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge just after the acceptance edge.
  task automatic send(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                      input logic cin, input logic sub);
    int t;
    t = 0;
    while (!in_ready && t < TMO) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_in_ready: got %0b want 1", in_ready);
    end
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
`ifdef WIDE_ADD_SUB_EN
    in_sub   = sub;
`endif
    exp_q.push_back(model(a, b, cin, sub));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    int t;
    t = 0;
    while (!out_valid && t < TMO) begin
      @(negedge clk);
      t++;
    end
    ok = (out_valid === 1'b1);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_cin = 1'b0;
`ifdef WIDE_ADD_SUB_EN
    in_sub = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_checks++; if (out_sum !== '0) begin n_fail++; $display("FAIL reset_out_sum: got %h want 0", out_sum); end
    n_checks++; if (out_cout !== 1'b0) begin n_fail++; $display("FAIL reset_out_cout: got %0b want 0", out_cout); end
    n_checks++; if (add_a !== '0 || add_b !== '0) begin n_fail++; $display("FAIL reset_add_ab: got %h/%h want 0/0", add_a, add_b); end
    n_checks++; if (add_cin !== 1'b0) begin n_fail++; $display("FAIL reset_add_cin: got %0b want 0", add_cin); end
  endtask

  task automatic test_carry_ripple();
    logic [DATA_W:0] e;
    send({DATA_W{1'b1}}, '0, 1'b1, 1'b0);
    for (int k = 0; k < NWORDS; k++) begin
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ripple_early_valid k=%0d: got %0b want 0", k, out_valid); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ripple_busy k=%0d: got %0b want 1", k, busy); end
      n_checks++; if (add_cin !== 1'b1) begin n_fail++; $display("FAIL ripple_add_cin k=%0d: got %0b want 1", k, add_cin); end
      n_checks++; if (add_a !== {ADD_W{1'b1}}) begin n_fail++; $display("FAIL ripple_add_a k=%0d: got %h want all ones", k, add_a); end
      @(negedge clk);
    end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ripple_latency: got out_valid %0b want 1", out_valid); end
    e = exp_q.pop_front();
    n_checks++; if (out_sum !== e[DATA_W-1:0]) begin n_fail++; $display("FAIL ripple_sum: got %h want %h", out_sum, e[DATA_W-1:0]); end
    n_checks++; if (out_cout !== e[DATA_W]) begin n_fail++; $display("FAIL ripple_cout: got %0b want %0b", out_cout, e[DATA_W]); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL ripple_return_idle: got ready %0b valid %0b want 1 0", in_ready, out_valid); end
  endtask

  task automatic test_carry_chain();
    logic [DATA_W-1:0] a, b, want;
    logic [DATA_W:0]   e;
    bit ok;
    a = '0; a[ADD_W-1:0] = {ADD_W{1'b1}};
    b = '0; b[0] = 1'b1;
    want = '0; want[ADD_W] = 1'b1;
    send(a, b, 1'b0, 1'b0);
    wait_valid(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL chain_timeout: got no out_valid want out_valid"); end
    e = exp_q.pop_front();
    n_checks++; if (out_sum !== want) begin n_fail++; $display("FAIL chain_sum_const: got %h want %h", out_sum, want); end
    n_checks++; if (out_sum !== e[DATA_W-1:0] || out_cout !== e[DATA_W]) begin n_fail++; $display("FAIL chain_model: got %0b_%h want %0b_%h", out_cout, out_sum, e[DATA_W], e[DATA_W-1:0]); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [DATA_W:0] e;
    bit ok;
    send(rand_data(), rand_data(), 1'($urandom_range(0, 1)), 1'b0);
    wait_valid(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_timeout: got no out_valid want out_valid"); end
    e = exp_q.pop_front();
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_a = rand_data(); in_b = rand_data(); in_cin = 1'($urandom_range(0, 1));
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid k=%0d: got %0b want 1", k, out_valid); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready k=%0d: got %0b want 0", k, in_ready); end
      n_checks++; if (out_sum !== e[DATA_W-1:0] || out_cout !== e[DATA_W]) begin n_fail++; $display("FAIL bp_hold k=%0d: got %0b_%h want %0b_%h", k, out_cout, out_sum, e[DATA_W], e[DATA_W-1:0]); end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got ready %0b busy %0b valid %0b want 1 0 0", in_ready, busy, out_valid); end
    @(negedge clk);
    n_checks++; if (out_sum !== e[DATA_W-1:0] || out_cout !== e[DATA_W]) begin n_fail++; $display("FAIL bp_result_kept: got %0b_%h want %0b_%h", out_cout, out_sum, e[DATA_W], e[DATA_W-1:0]); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_no_latch: got busy %0b want 0", busy); end
  endtask

  task automatic test_reset_mid_run();
    logic [DATA_W-1:0] want;
    logic [DATA_W:0]   e;
    bit ok, seen;
    send(rand_data(), rand_data(), 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ctrl: got valid %0b busy %0b ready %0b want 0 0 1", out_valid, busy, in_ready); end
    n_checks++; if (out_sum !== '0 || out_cout !== 1'b0) begin n_fail++; $display("FAIL midrst_result: got %0b_%h want 0_0", out_cout, out_sum); end
    n_checks++; if (add_a !== '0 || add_cin !== 1'b0) begin n_fail++; $display("FAIL midrst_adder: got %h %0b want 0 0", add_a, add_cin); end
    void'(exp_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (NWORDS + 2) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_checks++; if (seen) begin n_fail++; $display("FAIL midrst_no_valid: got out_valid pulse want none"); end
    send(DATA_W'(5), DATA_W'(7), 1'b0, 1'b0);
    wait_valid(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL midrst_timeout: got no out_valid want out_valid"); end
    e = exp_q.pop_front();
    want = DATA_W'(12);
    n_checks++; if (out_sum !== want || out_cout !== 1'b0) begin n_fail++; $display("FAIL midrst_5p7: got %0b_%h want 0_%h", out_cout, out_sum, want); end
    n_checks++; if (out_sum !== e[DATA_W-1:0]) begin n_fail++; $display("FAIL midrst_model: got %h want %h", out_sum, e[DATA_W-1:0]); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [DATA_W:0] e;
    bit ok;
    for (int n = 0; n < 12; n++) begin
      send(rand_data(), rand_data(), 1'($urandom_range(0, 1)), 1'b0);
      wait_valid(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL rand_timeout n=%0d: got no out_valid want out_valid", n); end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      e = exp_q.pop_front();
      n_checks++; if (out_sum !== e[DATA_W-1:0] || out_cout !== e[DATA_W]) begin n_fail++; $display("FAIL rand_result n=%0d: got %0b_%h want %0b_%h", n, out_cout, out_sum, e[DATA_W], e[DATA_W-1:0]); end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    int acc_cyc[$];
    int n_acc, n_res, t;
    bit acc;
    logic [DATA_W:0] e;
    n_acc = 0; n_res = 0; t = 0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = rand_data(); in_b = rand_data(); in_cin = 1'($urandom_range(0, 1));
    while ((n_acc < 4 || n_res < 4) && t < 200) begin
      if (out_valid && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_res++;
        n_checks++; if (out_sum !== e[DATA_W-1:0] || out_cout !== e[DATA_W]) begin n_fail++; $display("FAIL b2b_result r=%0d: got %0b_%h want %0b_%h", n_res, out_cout, out_sum, e[DATA_W], e[DATA_W-1:0]); end
      end
      acc = in_valid && in_ready;
      if (acc) begin
        exp_q.push_back(model(in_a, in_b, in_cin, 1'b0));
        acc_cyc.push_back(cyc);
        n_acc++;
      end
      @(negedge clk);
      t++;
      if (acc) begin
        if (n_acc < 4) begin
          in_a = rand_data(); in_b = rand_data(); in_cin = 1'($urandom_range(0, 1));
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_checks++; if (n_acc < 4 || n_res < 4) begin n_fail++; $display("FAIL b2b_timeout: got %0d/%0d want 4/4", n_acc, n_res); end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      n_checks++; if (acc_cyc[i] - acc_cyc[i-1] != NWORDS + 2) begin n_fail++; $display("FAIL b2b_interval i=%0d: got %0d want %0d", i, acc_cyc[i] - acc_cyc[i-1], NWORDS + 2); end
    end
  endtask

`ifdef WIDE_ADD_SUB_EN
  task automatic test_subtract();
    logic [DATA_W:0] e;
    bit ok;
    send('0, DATA_W'(1), 1'b0, 1'b1);
    wait_valid(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL sub_timeout0: got no out_valid want out_valid"); end
    e = exp_q.pop_front();
    n_checks++; if (out_sum !== {DATA_W{1'b1}} || out_cout !== 1'b0) begin n_fail++; $display("FAIL sub_0m1: got %0b_%h want 0_all ones", out_cout, out_sum); end
    n_checks++; if (out_sum !== e[DATA_W-1:0]) begin n_fail++; $display("FAIL sub_0m1_model: got %h want %h", out_sum, e[DATA_W-1:0]); end
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    send(DATA_W'(9), DATA_W'(4), 1'b1, 1'b1);
    wait_valid(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL sub_timeout1: got no out_valid want out_valid"); end
    e = exp_q.pop_front();
    n_checks++; if (out_sum !== DATA_W'(5) || out_cout !== 1'b1) begin n_fail++; $display("FAIL sub_9m4: got %0b_%h want 1_5", out_cout, out_sum); end
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    in_sub = 1'b0;
  endtask
`endif

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_carry_ripple();
    test_carry_chain();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    test_back_to_back();
`ifdef WIDE_ADD_SUB_EN
    test_subtract();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
